pipelined_cla_addsub: RTL
=========================

Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the combinational 8-bit CLA add/sub unit.
- Splits a WIDTH-bit operation into STAGES slices, one slice per pipeline stage. Carry is registered between stages; operands are skewed so a new operation can be accepted every cycle.
- Adds valid/ready handshakes, back-pressure stall and status flags (carry, signed overflow, zero, negative).
- Sits between the operand register file and the result writeback path.

Parameters:
- WIDTH, 16, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, pipeline depth; each stage computes SLICE = WIDTH/STAGES bits.
- GROUP, 4, lookahead group size inside a slice; must divide SLICE; carries between groups use group generate/propagate.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation present on x, y, mode, cin
- in_ready  output  1  block accepts operation this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- mode  input  1  0 = add, 1 = subtract
- cin  input  1  carry-in (borrow-not in subtract)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB
- overflow  output  1  signed two's-complement overflow
- zero  output  1  sum == 0
- negative  output  1  sum[WIDTH-1]

Behaviour:
- Reset (async, active-high):
  - All stage valid bits, out_valid, sum, cout, overflow, zero and negative are cleared to 0.
  - in_ready = 1 once reset deasserts.
- Arithmetic:
  - mode = 0: {cout, sum} = x + y + cin.
  - mode = 1: {cout, sum} = x + ~y + cin. cin = 1 gives x - y; cin = 0 gives x - y - 1. cout = 1 means no borrow.
- Overflow: overflow = carry into MSB XOR carry out of MSB, using the effective (possibly inverted) y.
- Flag timing: zero and negative are computed from the final full sum and are registered together with it.
- Slicing:
  - Stage k (0-based) computes bits [(k+1)*SLICE-1 : k*SLICE] from skew-registered x/y slices and the registered carry from stage k-1.
  - Stage 0 uses cin.
  - Lower result slices are delayed so the full sum emerges aligned.
- Latency: exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid = 1 when out_ready stays high.
- Throughput: one operation per cycle.
- Handshake:
  - Transfer occurs on a rising edge where valid & ready are both 1.
  - in_ready = !(out_valid & !out_ready).
  - When out_valid & !out_ready, the whole pipeline stalls: every stage register holds and sum and flags stay stable.
  - in_valid while in_ready = 0 is ignored; the source must hold its inputs.
- Bubbles: a stage with valid = 0 propagates a bubble. Data registers may update on bubbles, but out_valid stays 0 for them.
- Simultaneous events: with out_valid = 1 and out_ready = 1 on the same edge as a new accept, the output is consumed and the pipeline advances with no bubble inserted.
- Wrap-around: results are modulo 2^WIDTH; the carry is reported only on cout.
- Reset mid-operation: all in-flight operations are discarded and no partial result is ever presented.

Test Plan (defaults WIDTH=16, STAGES=4):
- Add with carry across a slice: x=0x00FF, y=0x0001, mode=0, cin=0, out_ready=1 → out_valid exactly 4 cycles after accept; sum=0x0100, cout=0, overflow=0, zero=0, negative=0.
- Full wrap: x=0xFFFF, y=0x0000, mode=0, cin=1 → sum=0x0000, cout=1, zero=1, overflow=0.
- Subtract:
  - x=0x007F, y=0x007E, mode=1, cin=1 → sum=0x0001, cout=1.
  - x=0x000A, y=0x0005, mode=1, cin=1 → sum=0x0005, cout=1.
  - x=0x0005, y=0x000A, mode=1, cin=1 → sum=0xFFFB, cout=0, negative=1.
- Signed overflow:
  - x=0x7FFF, y=0x0001, add, cin=0 → sum=0x8000, overflow=1, negative=1.
  - x=0x8000, y=0x0001, sub, cin=1 → sum=0x7FFF, overflow=1.
- Back-pressure:
  - Stream 6 back-to-back operations; drop out_ready for 3 cycles after the first result.
  - Required: out_valid stays high with sum and flags stable; in_ready = 0 during the stall.
  - All 6 results arrive in order with none lost or duplicated; throughput returns to 1 per cycle after release.
- Reset mid-stream: assert reset asynchronously (between edges) with 3 operations in flight → out_valid drops immediately and no stale result appears after release. The first post-reset operation returns after 4 cycles.

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// ---------------------------------------------------------------------------
// pipelined_cla_addsub
//
// Pipelined carry-lookahead adder/subtractor. A WIDTH-bit operation is split
// into STAGES slices of SLICE = WIDTH/STAGES bits, and each pipeline stage
// resolves one slice. Inside a slice, bits are grouped by GROUP. Each group
// computes its own generate/propagate terms, and the carries between groups
// are formed from those terms. The carry between slices is registered, so a
// new operation can enter every cycle. Operands travel with the operation and
// each stage uses only its own slice of them. Result slices that are already
// finished are carried forward, so the whole sum and its flags come out
// aligned on the final register.
//
// Parameter constraints: WIDTH % STAGES == 0 and SLICE % GROUP == 0.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operation present on x, y, mode, cin
//   in_ready   block accepts an operation this cycle
//   x, y       operands (WIDTH bits)
//   mode       0 = add, 1 = subtract (y is inverted)
//   cin        carry-in (borrow-not when subtracting)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        result, modulo 2^WIDTH
//   cout       carry out of the MSB (1 = no borrow when subtracting)
//   overflow   signed two's-complement overflow
//   zero       sum == 0
//   negative   sum[WIDTH-1]
//
// Pipeline shape: level 0 registers the accepted operands, with y already
// conditionally inverted. Levels 1..STAGES each hold the result of one more
// slice. Level STAGES is the output register, so the latency is STAGES
// cycles from the accepting edge.
// ---------------------------------------------------------------------------
module pipelined_cla_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int NGRP  = SLICE / GROUP;

  // Per-level pipeline state. Level k feeds stage k, and stage k writes
  // level k+1. Operands are needed only up to level STAGES-1.
  logic             valid_q   [0:STAGES];
  logic             valid_d   [0:STAGES];
  logic [WIDTH-1:0] x_q       [0:STAGES-1];
  logic [WIDTH-1:0] x_d       [0:STAGES-1];
  logic [WIDTH-1:0] y_q       [0:STAGES-1];
  logic [WIDTH-1:0] y_d       [0:STAGES-1];
  logic [WIDTH-1:0] sum_q     [0:STAGES];
  logic [WIDTH-1:0] sum_d     [0:STAGES];
  logic             carry_q   [0:STAGES];
  logic             carry_d   [0:STAGES];

  logic             overflow_q, overflow_d;
  logic             zero_q,     zero_d;
  logic             negative_q, negative_d;

  logic             advance;
  logic [SLICE+1:0] slice_r;

  // One slice of carry-lookahead addition.
  // The return value is {carry into the slice MSB, carry out, sum bits}.
  // Each group's generate/propagate produces the carry into the next group.
  // Inside a group, the bit carries are formed from the group carry-in.
  function automatic logic [SLICE+1:0] cla_slice(
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b,
    input logic             ci
  );
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [SLICE:0]   c;
    logic [NGRP:0]    gc;
    logic             grp_g;
    logic             grp_p;
    p     = a ^ b;
    g     = a & b;
    c     = '0;
    gc    = '0;
    grp_g = 1'b0;
    grp_p = 1'b1;
    gc[0] = ci;
    for (int j = 0; j < NGRP; j++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        grp_g = g[j*GROUP+i] | (p[j*GROUP+i] & grp_g);
        grp_p = grp_p & p[j*GROUP+i];
      end
      gc[j+1] = grp_g | (grp_p & gc[j]);
    end
    for (int j = 0; j < NGRP; j++) begin
      c[j*GROUP] = gc[j];
      for (int i = 0; i < GROUP - 1; i++) begin
        c[j*GROUP+i+1] = g[j*GROUP+i] | (p[j*GROUP+i] & c[j*GROUP+i]);
      end
    end
    c[SLICE] = gc[NGRP];
    return {c[SLICE-1], c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  // A held result that is not taken freezes the whole pipeline, so that
  // nothing is overwritten.
  assign advance = !(valid_q[STAGES] && !out_ready);

  always_comb begin
    slice_r    = '0;
    overflow_d = 1'b0;

    // Level 0: capture the operation. Inverting y here means every later
    // stage only adds.
    valid_d[0] = in_valid;
    x_d[0]     = x;
    y_d[0]     = mode ? ~y : y;
    sum_d[0]   = '0;
    carry_d[0] = cin;

    for (int k = 1; k < STAGES; k++) begin
      x_d[k] = x_q[k-1];
      y_d[k] = y_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      slice_r = cla_slice(x_q[k][k*SLICE +: SLICE],
                          y_q[k][k*SLICE +: SLICE],
                          carry_q[k]);
      valid_d[k+1]                  = valid_q[k];
      sum_d[k+1]                    = sum_q[k];
      sum_d[k+1][k*SLICE +: SLICE]  = slice_r[SLICE-1:0];
      carry_d[k+1]                  = slice_r[SLICE];
      // Overflow compares the carry into the MSB with the carry out of the
      // MSB. Both carries come from the top slice.
      if (k == STAGES - 1) begin
        overflow_d = slice_r[SLICE+1] ^ slice_r[SLICE];
      end
    end

    zero_d     = (sum_d[STAGES] == '0);
    negative_d = sum_d[STAGES][WIDTH-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= STAGES; k++) begin
        valid_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else if (advance) begin
      // Bubbles also move through the data registers. Only the valid bits
      // decide whether a result is presented.
      for (int k = 0; k <= STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
      end
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = valid_q[STAGES];
  assign sum       = sum_q[STAGES];
  assign cout      = carry_q[STAGES];
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign negative  = negative_q;

endmodule
